// File: rtl/apb3_reg_slave_pkg.sv
// Shared types for the APB3 register slave: FSM states, the address decode
// result and a helper for the byte-offset width of a data word.
package apb3_reg_slave_pkg;

   localparam int unsigned IDX_W      = 16;
   localparam int unsigned WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   typedef struct packed {
      logic             valid;
      logic             is_sr;
      logic [IDX_W-1:0] index;
   } decode_t;

   // log2 of the number of bytes per data word (8 -> 0, 16 -> 1, 32 -> 2).
   function automatic int unsigned byte_shift(input int unsigned data_width);
      case (data_width)
         8:       return 0;
         16:      return 1;
         default: return 2;
      endcase
   endfunction

   // An access errors when the decode is invalid or it writes a status register.
   function automatic logic access_err(input decode_t dec, input logic wr);
      return !dec.valid || (wr && dec.is_sr);
   endfunction

endpackage

// File: rtl/apb3_reg_slave_if.sv
// APB3 bus bundle for one slave select line.
//   master: drives paddr/psel/penable/pwrite/pwdata, receives pready/prdata/pslverr
//   slave : the reverse
interface apb3_reg_slave_if #(
   parameter int unsigned APB_ADDR_WIDTH_P = 16,
   parameter int unsigned APB_DATA_WIDTH_P = 32
);
   logic [APB_ADDR_WIDTH_P-1:0] paddr;
   logic                        psel;
   logic                        penable;
   logic                        pwrite;
   logic [APB_DATA_WIDTH_P-1:0] pwdata;
   logic                        pready;
   logic [APB_DATA_WIDTH_P-1:0] prdata;
   logic                        pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb3_addr_decoder.sv
// Combinational address decode: base subtraction, alignment and range check.
//   paddr    : byte address from the bus
//   decode_c : {valid, is_sr, index}; index is the word index relative to base
module apb3_addr_decoder
   import apb3_reg_slave_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH_P = 16,
   parameter int unsigned APB_DATA_WIDTH_P = 32,
   parameter int unsigned BASE_ADDR_P      = 0,
   parameter int unsigned NR_OF_CR_P       = 8,
   parameter int unsigned NR_OF_SR_P       = 4
) (
   input  logic [APB_ADDR_WIDTH_P-1:0] paddr,
   output decode_t                     decode_c
);
   localparam int unsigned   AW       = APB_ADDR_WIDTH_P;
   localparam int unsigned   SHIFT    = byte_shift(APB_DATA_WIDTH_P);
   localparam int unsigned   NR_REGS  = NR_OF_CR_P + NR_OF_SR_P;
   localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR_P);
   localparam logic [AW-1:0] OFS_MASK = AW'((1 << SHIFT) - 1);

   logic [AW:0]   diff;
   logic [AW-1:0] offset;
   logic [AW-1:0] word;
   logic          below;
   logic          misaligned;
   logic          beyond;

   // The borrow of the extended subtraction flags addresses below base.
   always_comb begin
      diff       = {1'b0, paddr} - {1'b0, BASE};
      below      = diff[AW];
      offset     = diff[AW-1:0];
      word       = offset >> SHIFT;
      misaligned = (offset & OFS_MASK) != '0;
      beyond     = word >= AW'(NR_REGS);

      decode_c.valid = !(below || misaligned || beyond);
      decode_c.is_sr = word >= AW'(NR_OF_CR_P);
      decode_c.index = IDX_W'(word);
   end
endmodule

// File: rtl/apb3_reg_slave.sv
// APB3 completer exposing read/write control registers and read-only status
// registers, with optional wait-state insertion.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : APB3 slave modport (paddr/psel/penable/pwrite/pwdata in,
//                 pready/prdata/pslverr out, all outputs registered)
//   cr_q        : control register contents
//   cr_wr_pulse : one-cycle pulse per control register written
//   sr_d        : status register values, sampled when the response is loaded
// Build option: define APB3_REG_SLAVE_WAIT_EN to enable the WAIT state and
// wait counter; otherwise every transfer completes in its first ACCESS cycle.
module apb3_reg_slave
   import apb3_reg_slave_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH_P = 16,
   parameter int unsigned APB_DATA_WIDTH_P = 32,
   parameter int unsigned BASE_ADDR_P      = 0,
   parameter int unsigned NR_OF_CR_P       = 8,
   parameter int unsigned NR_OF_SR_P       = 4,
   parameter int unsigned WAIT_STATES_P    = 2
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   apb3_reg_slave_if.slave                                  bus,
   output logic [NR_OF_CR_P-1:0][APB_DATA_WIDTH_P-1:0]      cr_q,
   output logic [NR_OF_CR_P-1:0]                            cr_wr_pulse,
   input  logic [((NR_OF_SR_P == 0) ? 1 : NR_OF_SR_P)-1:0]
                [APB_DATA_WIDTH_P-1:0]                      sr_d
);
   localparam int unsigned DW = APB_DATA_WIDTH_P;

   if (WAIT_STATES_P > 15) begin : g_bad_wait_states
      $error("apb3_reg_slave: WAIT_STATES_P must be 0..15");
   end
   if (DW != 8 && DW != 16 && DW != 32) begin : g_bad_data_width
      $error("apb3_reg_slave: APB_DATA_WIDTH_P must be 8, 16 or 32");
   end

   state_e                state_q, state_d;
   decode_t               decode_c, dec_q, dec_d;
   logic                  wr_q, wr_d;
   logic [DW-1:0]         wdata_q, wdata_d;
   logic                  pready_q, pready_d;
   logic [DW-1:0]         prdata_q, prdata_d;
   logic                  pslverr_q, pslverr_d;
   logic [NR_OF_CR_P-1:0] pulse_d;
`ifdef APB3_REG_SLAVE_WAIT_EN
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
`endif

   apb3_addr_decoder #(
      .APB_ADDR_WIDTH_P (APB_ADDR_WIDTH_P),
      .APB_DATA_WIDTH_P (APB_DATA_WIDTH_P),
      .BASE_ADDR_P      (BASE_ADDR_P),
      .NR_OF_CR_P       (NR_OF_CR_P),
      .NR_OF_SR_P       (NR_OF_SR_P)
   ) u_dec (
      .paddr    (bus.paddr),
      .decode_c (decode_c)
   );

   assign bus.pready  = pready_q;
   assign bus.prdata  = prdata_q;
   assign bus.pslverr = pslverr_q;

   // Next-state, transfer capture, write commit and response load.
   always_comb begin
      state_d   = state_q;
      dec_d     = dec_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      pready_d  = 1'b0;
      prdata_d  = '0;
      pslverr_d = 1'b0;
      pulse_d   = '0;
`ifdef APB3_REG_SLAVE_WAIT_EN
      cnt_d     = cnt_q;
`endif

      case (state_q)
         IDLE: begin
            // Only a SETUP phase starts a transfer; a stray penable is ignored.
            if (bus.psel && !bus.penable) begin
               dec_d   = decode_c;
               wr_d    = bus.pwrite;
               wdata_d = bus.pwdata;
`ifdef APB3_REG_SLAVE_WAIT_EN
               cnt_d   = WAIT_CNT_W'(WAIT_STATES_P);
               state_d = (WAIT_STATES_P == 0) ? RESP : WAIT;
`else
               state_d = RESP;
`endif
            end
         end
`ifdef APB3_REG_SLAVE_WAIT_EN
         WAIT: begin
            if (!bus.psel) begin
               state_d = IDLE;
            end else if (bus.penable) begin
               if (cnt_q <= WAIT_CNT_W'(1)) state_d = RESP;
               else                         cnt_d   = cnt_q - WAIT_CNT_W'(1);
            end
         end
`endif
         RESP: begin
            state_d = IDLE;
            // Commit only if the master still holds the ACCESS phase.
            if (bus.psel && bus.penable && wr_q && !access_err(dec_q, wr_q)) begin
               for (int unsigned i = 0; i < NR_OF_CR_P; i++) begin
                  pulse_d[i] = (dec_q.index == IDX_W'(i));
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Response is loaded on the edge that enters RESP; status is sampled here.
      if (state_d == RESP) begin
         pready_d  = 1'b1;
         pslverr_d = access_err(dec_d, wr_d);
         if (!pslverr_d && !wr_d) begin
            for (int unsigned i = 0; i < NR_OF_CR_P; i++) begin
               if (!dec_d.is_sr && dec_d.index == IDX_W'(i)) prdata_d = cr_q[i];
            end
            for (int unsigned i = 0; i < NR_OF_SR_P; i++) begin
               if (dec_d.is_sr && dec_d.index == IDX_W'(NR_OF_CR_P + i)) prdata_d = sr_d[i];
            end
         end
      end
   end

   // State, capture and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         dec_q       <= '0;
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         pready_q    <= 1'b0;
         prdata_q    <= '0;
         pslverr_q   <= 1'b0;
         cr_wr_pulse <= '0;
         cr_q        <= '0;
`ifdef APB3_REG_SLAVE_WAIT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         dec_q       <= dec_d;
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         pready_q    <= pready_d;
         prdata_q    <= prdata_d;
         pslverr_q   <= pslverr_d;
         cr_wr_pulse <= pulse_d;
`ifdef APB3_REG_SLAVE_WAIT_EN
         cnt_q       <= cnt_d;
`endif
         for (int unsigned i = 0; i < NR_OF_CR_P; i++) begin
            if (pulse_d[i]) cr_q[i] <= wdata_q;
         end
      end
   end
endmodule

// File: tb/tb_apb3_reg_slave.sv
// Self-checking bench for apb3_reg_slave: predicts each transfer's response,
// pulse and register state from a bench-side model and a scoreboard queue.
module tb_apb3_reg_slave;
   localparam int unsigned AW   = 16;
   localparam int unsigned DW   = 32;
   localparam int          NCR  = 8;
   localparam int          NSR  = 4;
   localparam logic [15:0] BASE = 16'h0100;
`ifdef APB3_REG_SLAVE_WAIT_EN
   localparam int          EXP_WS = 2;
`else
   localparam int          EXP_WS = 0;
`endif

   typedef struct {
      logic           wr;
      logic [DW-1:0]  rdata;
      logic           err;
      logic [NCR-1:0] pulse;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   apb3_reg_slave_if #(.APB_ADDR_WIDTH_P(AW), .APB_DATA_WIDTH_P(DW)) bus ();

   logic [NCR-1:0][DW-1:0] cr_q;
   logic [NCR-1:0]         cr_wr_pulse;
   logic [NSR-1:0][DW-1:0] sr_d;

   apb3_reg_slave #(
      .APB_ADDR_WIDTH_P (AW),
      .APB_DATA_WIDTH_P (DW),
      .BASE_ADDR_P      (32'h0000_0100),
      .NR_OF_CR_P       (NCR),
      .NR_OF_SR_P       (NSR),
      .WAIT_STATES_P    (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .cr_q        (cr_q),
      .cr_wr_pulse (cr_wr_pulse),
      .sr_d        (sr_d)
   );

   exp_t                   sb[$];
   logic [NCR-1:0][DW-1:0] cr_m;
   int                     n_chk  = 0;
   int                     n_fail = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t predict(input logic [15:0] addr, input logic wr);
      exp_t e;
      int   off;
      int   idx;
      e.wr    = wr;
      e.rdata = '0;
      e.err   = 1'b0;
      e.pulse = '0;
      off     = int'(addr) - int'(BASE);
      if (off < 0) e.err = 1'b1;
      else if (off % 4 != 0) e.err = 1'b1;
      else if (off / 4 >= NCR + NSR) e.err = 1'b1;
      else begin
         idx = off / 4;
         if (idx >= NCR) begin
            if (wr) e.err = 1'b1;
            else    e.rdata = sr_d[idx - NCR];
         end else if (wr) e.pulse[idx] = 1'b1;
         else             e.rdata = cr_m[idx];
      end
      return e;
   endfunction

   // Full transfer; enters and leaves at a negedge so transfers chain with no bubble.
   task automatic xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wdata);
      exp_t e;
      int   n;
      e = predict(addr, wr);
      sb.push_back(e);
      for (int i = 0; i < NCR; i++) if (e.pulse[i]) cr_m[i] = wdata;
      bus.paddr = addr; bus.pwrite = wr; bus.pwdata = wdata;
      bus.psel  = 1'b1; bus.penable = 1'b0;
      @(negedge clk);
      bus.penable = 1'b1;
      chk("pulse_not_held", 256'(cr_wr_pulse), 256'(0));
      n = 1;
      while (!bus.pready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("access_cycles", 256'(n), 256'(EXP_WS + 1));
      if (sb.size() == 0) chk("sb_empty", 256'(1), 256'(0));
      else begin
         e = sb.pop_front();
         chk("pslverr", 256'(bus.pslverr), 256'(e.err));
         if (!e.wr) chk("prdata", 256'(bus.prdata), 256'(e.rdata));
      end
      @(negedge clk);
      chk("wr_pulse", 256'(cr_wr_pulse), 256'(e.pulse));
      chk("cr_q", 256'(cr_q), 256'(cr_m));
   endtask

   task automatic idle();
      bus.psel = 1'b0; bus.penable = 1'b0;
      @(negedge clk);
      chk("pulse_gone", 256'(cr_wr_pulse), 256'(0));
   endtask

   initial begin
      logic [31:0] d;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = '0;  bus.pwdata  = '0;
      sr_d = '0;
      cr_m = '0;
      repeat (3) @(negedge clk);
      chk("rst_pready",  256'(bus.pready),  256'(0));
      chk("rst_prdata",  256'(bus.prdata),  256'(0));
      chk("rst_pslverr", 256'(bus.pslverr), 256'(0));
      chk("rst_cr_q",    256'(cr_q),        256'(0));
      chk("rst_pulse",   256'(cr_wr_pulse), 256'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Reset during the first ACCESS cycle of a CR write aborts it.
      bus.paddr = BASE + 16'h8; bus.pwrite = 1'b1; bus.pwdata = 32'hA5A5_A5A5;
      bus.psel = 1'b1; bus.penable = 1'b0;
      @(negedge clk);
      bus.penable = 1'b1;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("abort_rst_pready",  256'(bus.pready),  256'(0));
      chk("abort_rst_prdata",  256'(bus.prdata),  256'(0));
      chk("abort_rst_pslverr", 256'(bus.pslverr), 256'(0));
      chk("abort_rst_pulse",   256'(cr_wr_pulse), 256'(0));
      chk("abort_rst_cr_q",    256'(cr_q),        256'(0));
      bus.psel = 1'b0; bus.penable = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // CR write then read back.
      xfer(BASE + 16'h8, 1'b1, 32'hDEAD_BEEF);
      xfer(BASE + 16'h8, 1'b0, 32'h0);
      idle();

      // SR read and illegal SR write.
      sr_d[0] = 32'h0BAD_0000; sr_d[1] = 32'h1234_5678;
      sr_d[2] = 32'h5555_AAAA; sr_d[3] = 32'hFFFF_0001;
      xfer(BASE + 16'((NCR + 1) * 4), 1'b0, 32'h0);
      xfer(BASE + 16'((NCR + 1) * 4), 1'b1, 32'hFFFF_FFFF);
      xfer(BASE + 16'((NCR + 3) * 4), 1'b0, 32'h0);
      idle();

      // Error decodes: misaligned, below base, one past the last SR.
      xfer(BASE + 16'h2, 1'b0, 32'h0);
      xfer(BASE + 16'h2, 1'b1, 32'h1111_1111);
      xfer(BASE - 16'h4, 1'b0, 32'h0);
      xfer(BASE - 16'h4, 1'b1, 32'h2222_2222);
      xfer(BASE + 16'((NCR + NSR) * 4), 1'b0, 32'h0);
      xfer(BASE + 16'((NCR + NSR) * 4), 1'b1, 32'h3333_3333);
      idle();

      // penable without a SETUP in IDLE is ignored.
      bus.paddr = BASE + 16'h4; bus.pwrite = 1'b1; bus.pwdata = 32'h7777_7777;
      bus.psel = 1'b1; bus.penable = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stray_pready", 256'(bus.pready),  256'(0));
         chk("stray_pulse",  256'(cr_wr_pulse), 256'(0));
      end
      idle();

      // Master drops psel right after SETUP: no write, next transfer normal.
      bus.paddr = BASE + 16'hC; bus.pwrite = 1'b1; bus.pwdata = 32'h0BAD_F00D;
      bus.psel = 1'b1; bus.penable = 1'b0;
      @(negedge clk);
      bus.psel = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("drop_pulse", 256'(cr_wr_pulse), 256'(0));
      end
      chk("drop_cr_q", 256'(cr_q), 256'(cr_m));
      xfer(BASE + 16'hC, 1'b1, 32'h600D_F00D);
      xfer(BASE + 16'hC, 1'b0, 32'h0);
      idle();

      // 16 back-to-back writes followed by 16 back-to-back reads.
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         xfer(BASE + 16'((i % NCR) * 4), 1'b1, d);
      end
      for (int i = 0; i < 16; i++) xfer(BASE + 16'((i % NCR) * 4), 1'b0, 32'h0);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
